network_sender: RTL and testbench

- Transmit side of the five-wire inter-board link.
- Serializes a game-state data packet across four data lanes (serial_out_0..3) and handshake packets (ACK / game-lost) on serial_out_h.
- Runs stop-and-wait ARQ with a 1-bit sequence number: retransmits on timeout, advances on a matching ACK.
- Sits between game logic / control FSM (requests) and GPIO (serial lines); consumes ACK indications from the receive block.

---
 rtl/network_sender.sv | 239 +++++++++++++++++++++++
 tb/tb_network_sender.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/network_sender.sv
// Transmit side of the five-wire inter-board link: four-lane data frames under 1-bit
// stop-and-wait ARQ, plus an independent ACK / game-lost handshake line.
module network_sender #(
    parameter int unsigned          LANE_BITS      = 64,
    parameter int unsigned          SYNC_BITS      = 8,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD      = 8'hA5,
    parameter int unsigned          TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   game_active,
    input  logic                   init_seqNum,
    input  logic                   send_data,
    input  logic [4*LANE_BITS-1:0] packet_in,
    input  logic                   send_ready_ACK,
    input  logic                   ack_seqNum,
    input  logic                   send_game_lost,
    input  logic                   ack_received,
    input  logic                   received_seqNum_h,
    output logic                   serial_out_0,
    output logic                   serial_out_1,
    output logic                   serial_out_2,
    output logic                   serial_out_3,
    output logic                   serial_out_h,
    output logic                   data_busy,
    output logic                   hnd_busy,
    output logic                   send_done,
    output logic [3:0]             retransmit_cnt,
    output logic                   seqNum
);

    localparam int unsigned    PKT_BITS  = 4 * LANE_BITS;
    localparam int unsigned    HEAD_BITS = 8;
    localparam int unsigned    FRAME     = SYNC_BITS + LANE_BITS;
    localparam int unsigned    HFRAME    = SYNC_BITS + HEAD_BITS;
    localparam int unsigned    CW        = $clog2(FRAME);
    localparam int unsigned    HCW       = $clog2(HFRAME);
    localparam logic [CW-1:0]  LAST      = CW'(FRAME - 1);
    localparam logic [HCW-1:0] HLAST     = HCW'(HFRAME - 1);
    localparam logic [15:0]    TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic       H_IDLE   = 1'b0;
    localparam logic       H_SEND   = 1'b1;

    // Bit idx of each lane's frame {SYNC_WORD, lane payload}; bit 0 of the result is lane 0.
    function automatic logic [3:0] lane_bits(input logic [PKT_BITS-1:0] pkt,
                                             input logic [CW-1:0] idx);
        logic [PKT_BITS-1:0] sh;
        logic [FRAME-1:0]    fr;
        logic [3:0]          r;
        for (int l = 0; l < 4; l++) begin
            sh   = pkt >> ((3 - l) * LANE_BITS);
            fr   = {SYNC_WORD, sh[LANE_BITS-1:0]} << idx;
            r[l] = fr[FRAME-1];
        end
        return r;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [PKT_BITS-1:0] pkt_q, pkt_d;
    logic [PKT_BITS-1:0] pend_pkt_q, pend_pkt_d;
    logic [PKT_BITS-1:0] new_pkt;
    logic                pend_q, pend_d;
    logic                seq_q, seq_d;
    logic                done_q, done_d;
    logic [3:0]          rtx_q, rtx_d;
    logic [3:0]          lane_q, lane_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        pkt_d      = pkt_q;
        pend_d     = pend_q;
        pend_pkt_d = pend_pkt_q;
        seq_d      = seq_q;
        done_d     = 1'b0;
        rtx_d      = rtx_q;
        lane_d     = 4'b0;
        new_pkt    = send_data ? packet_in : pend_pkt_q;
        new_pkt[PKT_BITS-1 -: 4] = {4{seq_q}};

        if (send_data && state_q != IDLE) begin
            pend_d     = 1'b1;
            pend_pkt_d = packet_in;
        end

        case (state_q)
            IDLE: begin
                if (send_data || pend_q) begin
                    state_d = SEND;
                    pkt_d   = new_pkt;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    lane_d  = lane_bits(new_pkt, '0);
                end
            end
            SEND: begin
                if (cnt_q == LAST) begin
                    state_d = WAIT_ACK;
                    tmo_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    lane_d = lane_bits(pkt_q, cnt_q + CW'(1));
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + 16'd1;
                // A matching ACK beats a simultaneous timeout.
                if (ack_received && received_seqNum_h == ~seq_q) begin
                    seq_d   = ~seq_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = SEND;
                    tmo_d   = '0;
                    cnt_d   = '0;
                    lane_d  = lane_bits(pkt_q, '0);
                    if (rtx_q != 4'hF) rtx_d = rtx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!game_active) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            pend_d  = 1'b0;
            seq_d   = init_seqNum;
            done_d  = 1'b0;
            rtx_d   = '0;
            lane_d  = 4'b0;
        end
    end

    logic             h_state_q, h_state_d;
    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic [HFRAME-1:0] h_sh_q, h_sh_d;
    logic [HFRAME-1:0] h_frame;
    logic             h_out_q, h_out_d;
    logic             ack_pend_q, ack_pend_d;
    logic             lost_pend_q, lost_pend_d;

    always_comb begin
        h_state_d   = h_state_q;
        hcnt_d      = hcnt_q;
        h_sh_d      = h_sh_q;
        h_out_d     = 1'b0;
        h_frame     = '0;
        ack_pend_d  = ack_pend_q | send_ready_ACK;
        lost_pend_d = lost_pend_q | send_game_lost;

        if (h_state_q == H_SEND && hcnt_q != HLAST) begin
            hcnt_d  = hcnt_q + HCW'(1);
            h_out_d = h_sh_q[HFRAME-1];
            h_sh_d  = h_sh_q << 1;
        end else if (ack_pend_d || lost_pend_d) begin
            // Last bit of a frame doubles as the start cycle of the next one: no gap.
            if (lost_pend_d) begin
                h_frame     = {SYNC_WORD, 8'h00};
                lost_pend_d = 1'b0;
            end else begin
                h_frame    = {SYNC_WORD, {4{ack_seqNum}}, 4'hF};
                ack_pend_d = 1'b0;
            end
            h_state_d = H_SEND;
            hcnt_d    = '0;
            h_out_d   = h_frame[HFRAME-1];
            h_sh_d    = h_frame << 1;
        end else begin
            h_state_d = H_IDLE;
        end

        if (!game_active) begin
            h_state_d   = H_IDLE;
            hcnt_d      = '0;
            h_out_d     = 1'b0;
            ack_pend_d  = 1'b0;
            lost_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            pkt_q       <= '0;
            pend_q      <= 1'b0;
            pend_pkt_q  <= '0;
            seq_q       <= init_seqNum;
            done_q      <= 1'b0;
            rtx_q       <= '0;
            lane_q      <= '0;
            h_state_q   <= H_IDLE;
            hcnt_q      <= '0;
            h_sh_q      <= '0;
            h_out_q     <= 1'b0;
            ack_pend_q  <= 1'b0;
            lost_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            pkt_q       <= pkt_d;
            pend_q      <= pend_d;
            pend_pkt_q  <= pend_pkt_d;
            seq_q       <= seq_d;
            done_q      <= done_d;
            rtx_q       <= rtx_d;
            lane_q      <= lane_d;
            h_state_q   <= h_state_d;
            hcnt_q      <= hcnt_d;
            h_sh_q      <= h_sh_d;
            h_out_q     <= h_out_d;
            ack_pend_q  <= ack_pend_d;
            lost_pend_q <= lost_pend_d;
        end
    end

    assign serial_out_0   = lane_q[0];
    assign serial_out_1   = lane_q[1];
    assign serial_out_2   = lane_q[2];
    assign serial_out_3   = lane_q[3];
    assign serial_out_h   = h_out_q;
    assign data_busy      = (state_q != IDLE);
    assign hnd_busy       = (h_state_q != H_IDLE);
    assign send_done      = done_q;
    assign retransmit_cnt = rtx_q;
    assign seqNum         = seq_q;

endmodule

// File: tb/tb_network_sender.sv
// Directed bench for network_sender: data framing, ARQ ack/timeout/pending, handshake line,
// and game_active drop, with hand-computed expected frames.
module tb_network_sender;

    logic         clk = 1'b0;
    logic         rst_l, game_active, init_seqNum, send_data;
    logic [255:0] packet_in;
    logic         send_ready_ACK, ack_seqNum, send_game_lost, ack_received, received_seqNum_h;
    logic         serial_out_0, serial_out_1, serial_out_2, serial_out_3, serial_out_h;
    logic         data_busy, hnd_busy, send_done, seqNum;
    logic [3:0]   retransmit_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] l0v, l1v, l2v, l3v, c0v, c1v, c2v, c3v, onev;
    logic [71:0] f0, f1, f2, f3;
    logic [47:0] hstream;
    int          bc, idle_bits, busy_cnt;

    network_sender dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .game_active       (game_active),
        .init_seqNum       (init_seqNum),
        .send_data         (send_data),
        .packet_in         (packet_in),
        .send_ready_ACK    (send_ready_ACK),
        .ack_seqNum        (ack_seqNum),
        .send_game_lost    (send_game_lost),
        .ack_received      (ack_received),
        .received_seqNum_h (received_seqNum_h),
        .serial_out_0      (serial_out_0),
        .serial_out_1      (serial_out_1),
        .serial_out_2      (serial_out_2),
        .serial_out_3      (serial_out_3),
        .serial_out_h      (serial_out_h),
        .data_busy         (data_busy),
        .hnd_busy          (hnd_busy),
        .send_done         (send_done),
        .retransmit_cnt    (retransmit_cnt),
        .seqNum            (seqNum)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collects 72 bits per lane starting the cycle after acceptance; optional ACK pulse at step.
    task automatic run_frame(input int ack_at, input logic ack_seq,
                             output logic [71:0] a0, output logic [71:0] a1,
                             output logic [71:0] a2, output logic [71:0] a3, output int busy);
        busy = 0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        for (int k = 0; k < 72; k++) begin
            tick();
            send_data = 1'b0;
            a0 = {a0[70:0], serial_out_0};
            a1 = {a1[70:0], serial_out_1};
            a2 = {a2[70:0], serial_out_2};
            a3 = {a3[70:0], serial_out_3};
            busy += int'(data_busy);
            ack_received      = (k == ack_at);
            received_seqNum_h = ack_seq;
        end
        ack_received = 1'b0;
    endtask

    function automatic logic [71:0] exp_lane(input logic [63:0] p);
        return {8'hA5, p};
    endfunction

    function automatic logic [71:0] exp_lane0(input logic [63:0] p, input logic s);
        logic [63:0] q;
        q = p;
        q[63:60] = {4{s}};
        return {8'hA5, q};
    endfunction

    initial begin
        l0v = 64'hFEDC_BA98_7654_3210;
        l1v = 64'h0123_4567_89AB_CDEF;
        l2v = 64'hAAAA_5555_F0F0_0F0F;
        l3v = 64'h8000_0000_0000_0001;
        c0v = 64'h5C5C_0000_1234_5678;
        c1v = 64'hC0FF_EE00_DEAD_BEEF;
        c2v = 64'h0F0F_0F0F_0F0F_0F0F;
        c3v = 64'h7777_8888_9999_AAAA;
        onev = '1;

        rst_l = 1'b0; game_active = 1'b1; init_seqNum = 1'b1; send_data = 1'b0;
        packet_in = '0; send_ready_ACK = 1'b0; ack_seqNum = 1'b0; send_game_lost = 1'b0;
        ack_received = 1'b0; received_seqNum_h = 1'b0;
        #12;
        check("reset_lines", {serial_out_0, serial_out_1, serial_out_2, serial_out_3,
                              serial_out_h}, 5'b0);
        check("reset_busy", {data_busy, hnd_busy, send_done}, 3'b0);
        check("reset_rtx", retransmit_cnt, 4'd0);
        check("reset_seq", seqNum, 1'b1);
        @(negedge clk);
        rst_l = 1'b1;
        tick();

        // All-ones packet with seqNum 1
        packet_in = '1;
        send_data = 1'b1;
        run_frame(-1, 1'b0, f0, f1, f2, f3, bc);
        check("ones_lane0", f0, exp_lane0(onev, 1'b1));
        check("ones_lane1", f1, exp_lane(onev));
        check("ones_lane3", f3, exp_lane(onev));
        check("ones_busy_cycles", bc, 72);
        tick();
        check("wait_lines_idle", {serial_out_0, serial_out_1, serial_out_2, serial_out_3}, 4'b0);
        check("wait_busy", data_busy, 1'b1);
        ack_received = 1'b1; received_seqNum_h = 1'b1;  // wrong seqNum
        tick();
        ack_received = 1'b0;
        check("bad_ack_seq", seqNum, 1'b1);
        check("bad_ack_done", {send_done, data_busy}, 2'b01);
        repeat (8) tick();
        ack_received = 1'b1; received_seqNum_h = 1'b0;
        tick();
        ack_received = 1'b0;
        check("ack_done", {send_done, seqNum, data_busy}, 3'b100);
        tick();
        check("ack_done_pulse", send_done, 1'b0);

        // Distinct lanes with seqNum 0, then timeout and retransmit
        packet_in = {l0v, l1v, l2v, l3v};
        send_data = 1'b1;
        run_frame(-1, 1'b0, f0, f1, f2, f3, bc);
        check("p1_lane0", f0, exp_lane0(l0v, 1'b0));
        check("p1_lane1", f1, exp_lane(l1v));
        check("p1_lane2", f2, exp_lane(l2v));
        check("p1_lane3", f3, exp_lane(l3v));
        idle_bits = 0; busy_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            idle_bits += int'(serial_out_0 | serial_out_1 | serial_out_2 | serial_out_3);
            busy_cnt  += int'(data_busy);
            ack_received = (k == 4);
            received_seqNum_h = 1'b0;  // equals seqNum: not a valid ACK
        end
        ack_received = 1'b0;
        check("timeout_idle_bits", idle_bits, 0);
        check("timeout_busy", busy_cnt, 256);
        check("timeout_rtx_before", retransmit_cnt, 4'd0);
        run_frame(5, 1'b1, f0, f1, f2, f3, bc);  // ACK during SEND is ignored
        check("rtx_lane0", f0, exp_lane0(l0v, 1'b0));
        check("rtx_lane2", f2, exp_lane(l2v));
        check("rtx_lane3", f3, exp_lane(l3v));
        check("rtx_cnt1", retransmit_cnt, 4'd1);
        check("rtx_seq", {seqNum, send_done}, 2'b00);
        repeat (16 * 328) tick();
        check("rtx_saturate", retransmit_cnt, 4'd15);
        check("rtx_still_busy", data_busy, 1'b1);

        // Ack P1, then pending overwrite A, B, C during P
        tick();
        ack_received = 1'b1; received_seqNum_h = 1'b1;
        tick();
        ack_received = 1'b0;
        check("p1_acked", {send_done, seqNum, data_busy}, 3'b110);
        packet_in = '0;
        send_data = 1'b1;
        tick();
        packet_in = {4{64'hAAAA_AAAA_AAAA_AAAA}};
        tick();
        packet_in = {4{64'hBBBB_BBBB_BBBB_BBBB}};
        tick();
        packet_in = {c0v, c1v, c2v, c3v};
        tick();
        send_data = 1'b0;
        packet_in = '0;
        repeat (68) tick();
        tick();
        ack_received = 1'b1; received_seqNum_h = 1'b0;
        tick();
        ack_received = 1'b0;
        check("p_acked", {send_done, seqNum, data_busy}, 3'b100);
        run_frame(-1, 1'b0, f0, f1, f2, f3, bc);
        check("c_lane0", f0, exp_lane0(c0v, 1'b0));
        check("c_lane1", f1, exp_lane(c1v));
        check("c_lane3", f3, exp_lane(c3v));
        tick();
        ack_received = 1'b1; received_seqNum_h = 1'b1;
        tick();
        ack_received = 1'b0;
        check("c_acked", {send_done, seqNum}, 2'b11);
        tick();
        check("no_leftover_pending", {data_busy, send_done}, 2'b00);

        // Handshake: game-lost wins, ACK follows, later requests collapse into one ACK
        ack_seqNum = 1'b1; send_ready_ACK = 1'b1; send_game_lost = 1'b1;
        hstream = '0; busy_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            send_game_lost = 1'b0;
            send_ready_ACK = (k == 19 || k == 21);
            if (k == 24) ack_seqNum = 1'b0;
            hstream = {hstream[46:0], serial_out_h};
            busy_cnt += int'(hnd_busy);
        end
        send_ready_ACK = 1'b0;
        check("hnd_stream", hstream, 48'hA500_A5FF_A50F);
        check("hnd_busy_cycles", busy_cnt, 48);
        tick();
        check("hnd_idle", {hnd_busy, serial_out_h}, 2'b00);

        // game_active drop mid-frame
        init_seqNum = 1'b0;
        packet_in = {l0v, l1v, l2v, l3v};
        send_data = 1'b1; send_game_lost = 1'b1;
        tick();
        send_data = 1'b0; send_game_lost = 1'b0;
        tick();
        send_data = 1'b1; packet_in = {c0v, c1v, c2v, c3v};
        tick();
        send_data = 1'b0;
        repeat (8) tick();
        check("drop_pre_busy", {data_busy, hnd_busy}, 2'b11);
        game_active = 1'b0;
        tick();
        check("drop_lines", {serial_out_0, serial_out_1, serial_out_2, serial_out_3,
                             serial_out_h}, 5'b0);
        check("drop_state", {data_busy, hnd_busy, send_done, seqNum}, 4'b0000);
        check("drop_rtx", retransmit_cnt, 4'd0);
        game_active = 1'b1;
        tick();
        check("drop_after_1", {data_busy, hnd_busy, send_done}, 3'b000);
        repeat (3) tick();
        check("drop_after_4", {data_busy, send_done}, 2'b00);
        packet_in = '1;
        send_data = 1'b1;
        run_frame(-1, 1'b0, f0, f1, f2, f3, bc);
        check("post_drop_lane0", f0, exp_lane0(onev, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
